fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter sequencer and fetch stage for the RISC-V core. Owns the PC, drives the byte address of the combinational instruction memory, and registers each fetched instruction with its PC into a one-entry output stage handed to decode over a valid/ready handshake. Handles branch/jump redirects, an external halt, and alignment and range faults so the instruction memory never sees an illegal address.

## Interface
- `ADDR_WIDTH`, 8: byte address space of instruction memory is 2^ADDR_WIDTH bytes.
- `INSTRUCTION_WIDTH`, 32: instruction and PC width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_addr`  out  INSTRUCTION_WIDTH  byte address to instruction memory; always equals the current PC.
- `imem_instruction`  in  INSTRUCTION_WIDTH  combinational read data for `imem_addr`.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  INSTRUCTION_WIDTH  target PC.
- `halt`  in  1  stop issuing new fetches while high.
- `out_valid`  out  1  output stage holds a valid instruction.
- `out_ready`  in  1  decode accepts the output this cycle.
- `out_instruction`  out  INSTRUCTION_WIDTH  fetched instruction.
- `out_pc`  out  INSTRUCTION_WIDTH  PC of `out_instruction`.
- `fault`  out  1  sticky fetch fault.
- `fault_pc`  out  INSTRUCTION_WIDTH  PC that caused the fault.
- `fetch_count`  out  32  count of accepted handshakes; wraps modulo 2^32.

## Operation
- States: RUN, FAULT. Reset enters RUN.
- Reset values: pc=RESET_PC, out_valid=0, out_instruction=32'h0000_0013 (NOP), out_pc=0, fault=0, fault_pc=0, fetch_count=0.
- `load = (!out_valid || out_ready) && !halt && state==RUN && !redirect_valid`.
- Legal PC: pc[1:0]==0 and pc[31:ADDR_WIDTH]==0.
- RUN, load, legal pc: out_instruction<=imem_instruction, out_pc<=pc, out_valid<=1, pc<=pc+4.
- RUN, load, illegal pc: enter FAULT. fault<=1, fault_pc<=pc, out_valid<=0 unless a held entry is not consumed this cycle.
- RUN, no load: if out_valid && out_ready, then out_valid<=0. Otherwise hold the output unchanged.
- `redirect_valid` has priority over halt and load, in RUN or FAULT. It sets pc<=redirect_pc and out_valid<=0, flushing the held entry even if out_ready is high. fetch_count does not increment on a flushed entry. A redirect in FAULT updates pc but does not leave FAULT.
- Misaligned or out-of-range redirect targets are not checked at redirect time. They fault when fetched.
- Sequential fall-through past the top of memory (pc == 2^ADDR_WIDTH) faults with fault_pc = 2^ADDR_WIDTH.
- In FAULT: no loads. A held valid entry still drains on out_ready. Only rst leaves FAULT.
- halt: new loads stop, and a held entry still drains. Deasserting halt resumes at the current pc.
- fetch_count increments on out_valid && out_ready && !redirect_valid.

## Timing
- First rising edge after rst deasserts loads RESET_PC. out_valid is high in the following cycle, which is 1-cycle fetch latency.
- Steady state with out_ready=1: one instruction per cycle, out_pc incrementing by 4.
- Redirect sampled at edge N: out_valid=0 during cycle N+1. An entry with out_pc=redirect_pc is valid in cycle N+2 (2-cycle redirect penalty).
- Backpressure: while out_valid && !out_ready, out_instruction, out_pc and pc are stable.
- Halt asserted in cycle N: no load at edge N. Deasserted in cycle M: a load occurs at edge M.
- rst assertion mid-operation forces all reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `riscv_core_pkg` holds:
  - fetch state enum (`FETCH_RUN`, `FETCH_FAULT`)
  - `NOP_INSTRUCTION` = 32'h0000_0013
  - `INSN_BYTES` = 4
- No sub-module. PC register, output stage, FSM and counter live in one module next to instruction_memory.

## Test plan
- Reset with RESET_PC=0, out_ready=1, imem preloaded with a known pattern: out_pc sequence 0,4,8,… from cycle 1, with matching instructions; fetch_count=N after N cycles.
- Hold out_ready=0 for 5 cycles mid-stream at out_pc=0x10: out_pc and out_instruction stay at 0x10, imem_addr=0x14. Release: 0x14 appears next cycle with no duplicate or skip.
- Redirect to 0x40 while the output holds 0x08 with out_ready=1: 0x08 is flushed and not counted. out_valid=0 for one cycle, then out_pc=0x40.
- Redirect to 0x42: fault=1, fault_pc=0x42, out_valid stays 0; a later redirect to 0x00 does not clear fault; rst does.
- ADDR_WIDTH=8, run sequentially from 0xF8: 0xF8 and 0xFC are delivered, then fault=1 with fault_pc=0x100.
- Assert halt for 3 cycles with out_ready=1, then assert rst asynchronously mid-stream: no new out_pc during halt, and all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/riscv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_pkg
// Description : Shared types and constants for the RISC-V core.
//               FETCH_RUN / FETCH_FAULT : fetch sequencer states
//               NOP_INSTRUCTION         : canonical NOP (addi x0, x0, 0)
//               INSN_BYTES              : bytes per instruction word
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_core_pkg;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
    localparam int unsigned INSN_BYTES      = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC sequencer and fetch stage. Drives the combinational
//               instruction memory with the current PC and registers each
//               fetched word plus its PC into a one-entry valid/ready output
//               stage. Handles redirects, halt and alignment/range faults.
// Ports       : clk, rst (async, active-high)
//               imem_addr / imem_instruction   : instruction memory port
//               redirect_valid / redirect_pc   : taken branch/jump
//               halt                           : suspend new fetches
//               out_valid / out_ready / out_instruction / out_pc : to decode
//               fault / fault_pc               : sticky fetch fault
//               fetch_count                    : accepted handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_core_pkg::*;
#(
    parameter int unsigned                  ADDR_WIDTH        = 8,
    parameter int unsigned                  INSTRUCTION_WIDTH = 32,
    parameter logic [INSTRUCTION_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [INSTRUCTION_WIDTH-1:0] imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
    input  logic                         redirect_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] redirect_pc,
    input  logic                         halt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [INSTRUCTION_WIDTH-1:0] out_pc,
    output logic                         fault,
    output logic [INSTRUCTION_WIDTH-1:0] fault_pc,
    output logic [31:0]                  fetch_count
);

    localparam logic [INSTRUCTION_WIDTH-1:0] c_insn_step = INSTRUCTION_WIDTH'(INSN_BYTES);
    localparam logic [INSTRUCTION_WIDTH-1:0] c_nop       = INSTRUCTION_WIDTH'(NOP_INSTRUCTION);

    fetch_state_t                   r_state;
    fetch_state_t                   w_state_next;
    logic [INSTRUCTION_WIDTH-1:0]   r_pc;
    logic                           w_load;
    logic                           w_legal;
    logic                           w_accept;

    assign imem_addr = r_pc;

    // Word aligned and inside the 2^ADDR_WIDTH byte window; anything else
    // must never reach the memory as a real fetch.
    assign w_legal  = (r_pc[1:0] == 2'b00) && ((r_pc >> ADDR_WIDTH) == '0);

    // A fetch happens only when the output slot is free or being freed.
    assign w_load   = (!out_valid || out_ready) && !halt &&
                      (r_state == FETCH_RUN) && !redirect_valid;

    // A redirect flushes the held entry, so it is never counted as accepted.
    assign w_accept = out_valid && out_ready && !redirect_valid;

    // FAULT is sticky: only reset returns to RUN.
    always_comb begin
        w_state_next = r_state;
        if ((r_state == FETCH_RUN) && w_load && !w_legal) begin
            w_state_next = FETCH_FAULT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            out_valid       <= 1'b0;
            out_instruction <= c_nop;
            out_pc          <= '0;
            fault           <= 1'b0;
            fault_pc        <= '0;
        end else if (redirect_valid) begin
            r_pc      <= redirect_pc;
            out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_legal) begin
                out_instruction <= imem_instruction;
                out_pc          <= r_pc;
                out_valid       <= 1'b1;
                r_pc            <= r_pc + c_insn_step;
            end else begin
                // w_load guarantees any held entry is consumed this cycle.
                fault     <= 1'b1;
                fault_pc  <= r_pc;
                out_valid <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (w_accept) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit. A behavioural instruction
//               memory returns a fixed address-derived pattern; expected
//               (pc, instruction) pairs are queued as stimulus is driven and
//               popped on every accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'h5A00_0000 ^ {a[15:0], ~a[15:0]};
    endfunction

    assign imem_instruction = pat(imem_addr);

    fetch_unit #(
        .ADDR_WIDTH       (8),
        .INSTRUCTION_WIDTH(32),
        .RESET_PC         (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_instruction(imem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .fault           (fault),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_underflow: observed out_pc %h expected no handshake", out_pc);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb_q.pop_front();
                check("sb_pc", out_pc, exp_pc);
                check("sb_insn", out_instruction, pat(exp_pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_insn", out_instruction, 32'h0000_0013);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
    endtask

    // Asserts rst between edges, checks values, releases rst just after an
    // edge so the next rising edge is the first fetch.
    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt           = 1'b0;
        out_ready      = 1'b1;
        #1;
        check_reset_values();
        check("sb_empty", sb_q.size(), 32'd0);
        sb_q.delete();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt           = 1'b0;
        out_ready      = 1'b1;

        // ---- Streaming and backpressure ----
        do_reset();
        for (int i = 0; i < 7; i++) sb_q.push_back(32'(i * 4));
        step();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_pc", out_pc, 32'd0);
        repeat (4) step();
        check("stream_pc", out_pc, 32'h10);
        check("stream_count", fetch_count, 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_pc", out_pc, 32'h10);
            check("bp_insn", out_instruction, pat(32'h10));
            check("bp_imem_addr", imem_addr, 32'h14);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_pc", out_pc, 32'h14);
        repeat (2) step();
        check("stream_count2", fetch_count, 32'd7);

        // ---- Redirect flush ----
        do_reset();
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        repeat (3) step();
        check("pre_redir_pc", out_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        check("redir_imem_addr", imem_addr, 32'h40);
        check("redir_count", fetch_count, 32'd2);
        step();
        check("redir_valid", {31'd0, out_valid}, 32'd1);
        check("redir_pc", out_pc, 32'h40);
        sb_q.push_back(32'h40);
        step();
        check("redir_count2", fetch_count, 32'd3);

        // ---- Misaligned redirect target faults ----
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("mis_imem_addr", imem_addr, 32'h42);
        check("mis_pre_fault", {31'd0, fault}, 32'd0);
        step();
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_fault_pc", fault_pc, 32'h42);
        check("mis_valid", {31'd0, out_valid}, 32'd0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("fault_redir_addr", imem_addr, 32'h0);
        repeat (2) step();
        check("fault_sticky", {31'd0, fault}, 32'd1);
        check("fault_sticky_pc", fault_pc, 32'h42);
        check("fault_no_load", {31'd0, out_valid}, 32'd0);

        // ---- Fall-through past top of memory ----
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF8;
        sb_q.push_back(32'hF8);
        sb_q.push_back(32'hFC);
        step();
        redirect_valid = 1'b0;
        step();
        check("top_pc_f8", out_pc, 32'hF8);
        step();
        check("top_pc_fc", out_pc, 32'hFC);
        step();
        check("top_fault", {31'd0, fault}, 32'd1);
        check("top_fault_pc", fault_pc, 32'h100);
        check("top_valid", {31'd0, out_valid}, 32'd0);
        check("top_count", fetch_count, 32'd2);
        step();
        check("top_valid2", {31'd0, out_valid}, 32'd0);

        // ---- Halt, then asynchronous reset mid-stream ----
        do_reset();
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        repeat (2) step();
        check("halt_pre_pc", out_pc, 32'h4);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_valid", {31'd0, out_valid}, 32'd0);
            check("halt_imem_addr", imem_addr, 32'h8);
        end
        halt = 1'b0;
        sb_q.push_back(32'h8);
        step();
        check("resume_pc", out_pc, 32'h8);
        check("resume_count", fetch_count, 32'd2);
        step();
        check("resume_pc2", out_pc, 32'hC);
        #1;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
